// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- multi-cycle restoring radix-2 divider for the EX stage.
//
// Performs signed (DIV) or unsigned (DIVU) 32-bit division, one quotient bit
// per clock. The result is {remainder, quotient}, which maps to {HI, LO}.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset (0 = reset)
//   signed_div_i  1 = signed divide, 0 = unsigned divide
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       request; EX holds it high until the result is consumed
//   annul_i       cancel the operation in flight (branch/flush)
//   result_o      {remainder[63:32], quotient[31:0]}
//   ready_o       result_o is valid
//   busy_o        division in progress (EX stall request)
//
// Timing: acceptance edge E0, iterations on E1..E32, result registered on
// E33. A zero divisor finishes one edge after acceptance with result 0.
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [5:0]             cnt_q, cnt_d;
    // {partial remainder (33 bits), quotient/dividend (32 bits)}
    logic [2*DATA_W:0]      work_q, work_d;
    logic [DATA_W-1:0]      divisor_q, divisor_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]    result_q, result_d;

    // Operand magnitudes at acceptance. The most negative value negates to
    // itself, which read as unsigned is exactly 2^31, so no special case.
    logic                   op1_neg, op2_neg;
    logic [DATA_W-1:0]      op1_abs, op2_abs;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step: shift the whole register left, then try to
    // subtract the divisor from the 33-bit partial remainder.
    logic [2*DATA_W:0]      shifted;
    logic [DATA_W:0]        partial;
    logic [DATA_W:0]        diff;
    logic [2*DATA_W:0]      step_out;

    always_comb begin
        shifted = work_q << 1;
        partial = shifted[2*DATA_W:DATA_W];
        diff    = partial - {1'b0, divisor_q};
        if (partial >= {1'b0, divisor_q}) begin
            step_out = {diff, shifted[DATA_W-1:1], 1'b1};
        end else begin
            step_out = shifted;
        end
    end

    // Sign correction of the finished magnitudes; wraps modulo 2^32.
    logic [DATA_W-1:0]      quot_raw, rem_raw;
    logic [DATA_W-1:0]      quot_fix, rem_fix;

    assign quot_raw = work_q[DATA_W-1:0];
    assign rem_raw  = work_q[2*DATA_W-1:DATA_W];
    assign quot_fix = neg_quot_q ? (~quot_raw + 1'b1) : quot_raw;
    assign rem_fix  = neg_rem_q  ? (~rem_raw  + 1'b1) : rem_raw;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;

        unique case (state_q)
            FREE: begin
                // annul_i suppresses acceptance in the same cycle
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d    = ON;
                        cnt_d      = '0;
                        work_d     = {{(DATA_W+1){1'b0}}, op1_abs};
                        divisor_d  = op2_abs;
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                    end
                end
            end

            BYZERO: begin
                result_d = '0;
                state_d  = annul_i ? FREE : END;
            end

            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    cnt_d    = '0;
                    result_d = '0;
                end else if (cnt_q == 6'(DATA_W)) begin
                    // All quotient bits are in; no further shift here.
                    result_d = {rem_fix, quot_fix};
                    state_d  = END;
                end else begin
                    work_d = step_out;
                    cnt_d  = cnt_q + 6'd1;
                end
            end

            END: begin
                // Hold the result until EX drops its request.
                if (!start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = FREE;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

    // Both flags decode the state register directly, so they are glitch-free
    // registered outputs.
    assign result_o = result_q;
    assign ready_o  = (state_q == END);
    assign busy_o   = (state_q == BYZERO) || (state_q == ON);

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- scoreboard bench for div_unit.
// Stimulus pushes the hand-computed result and latency for each accepted
// operation; a monitor pops and compares whenever ready_o rises.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic ready_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: one comparison pair per result presented by the DUT.
    always @(negedge clk) begin
        if (ready_o === 1'b1 && ready_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ready: got result %h with no operation pending", result_o);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_result"}, result_o, mon_e.res);
                check({mon_e.name, "_latency"}, 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                $display("txn %-14s result=%h latency=%0d", mon_e.name, result_o, cyc - mon_e.acc);
            end
        end
        ready_prev <= ready_o;
    end

    // Issue one operation (caller is at a negedge), scramble the operands
    // after acceptance, hold start_i in END for `hold` cycles (or drop it
    // during the computation), then check the return to FREE.
    task automatic run_div(input string name, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input bit drop_start, input int hold);
        exp_t e;
        bit   got;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        @(posedge clk); #1;
        e.res  = exp;
        e.lat  = (b == 32'd0) ? 1 : 33;
        e.acc  = cyc;
        e.name = name;
        sb.push_back(e);
        check({name, "_busy"}, 64'(busy_o), 64'(1));
        opdata1_i = ~a;
        opdata2_i = b ^ 32'h5A5A_0003;
        if (drop_start) start_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: ready_o=%b after 40 cycles, required 1", name, ready_o);
            start_i = 1'b0;
            repeat (3) @(negedge clk);
            return;
        end
        if (!drop_start) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check({name, "_hold_ready"}, 64'(ready_o), 64'(1));
                check({name, "_hold_result"}, result_o, exp);
            end
            start_i = 1'b0;
        end
        @(posedge clk); #1;
        check({name, "_free_ready"}, 64'(ready_o), 64'(0));
        check({name, "_free_result"}, result_o, 64'(0));
        check({name, "_free_busy"}, 64'(busy_o), 64'(0));
    endtask

    initial begin
        #1 rst = 1'b0;
        #2;
        check("reset_result", result_o, 64'(0));
        check("reset_ready", 64'(ready_o), 64'(0));
        check("reset_busy", 64'(busy_o), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        @(negedge clk) run_div("divu_100_7",   0, 32'd100,       32'd7,         {32'h0000_0002, 32'h0000_000E}, 0, 5);
        @(negedge clk) run_div("div_m7_2",     1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 1);
        @(negedge clk) run_div("div_7_m2",     1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 0, 1);
        @(negedge clk) run_div("div_by_zero",  1, 32'h0000_1234, 32'd0,         64'h0, 0, 2);
        @(negedge clk) run_div("div_ovf",      1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 0, 1);
        @(negedge clk) run_div("divu_max_1",   0, 32'hFFFF_FFFF, 32'd1,         {32'h0000_0000, 32'hFFFF_FFFF}, 0, 1);
        @(negedge clk) run_div("divu_max_16",  0, 32'hFFFF_FFFF, 32'd16,        {32'h0000_000F, 32'h0FFF_FFFF}, 0, 1);
        @(negedge clk) run_div("div_m8_m3",    1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'h0000_0002}, 0, 1);
        @(negedge clk) run_div("divu_5_9_drop",0, 32'd5,         32'd9,         {32'h0000_0005, 32'h0000_0000}, 1, 0);
        @(negedge clk) run_div("div_min_2",    1, 32'h8000_0000, 32'd2,         {32'h0000_0000, 32'hC000_0000}, 0, 1);
        @(negedge clk) run_div("divu_min_max", 0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 0, 1);
        @(negedge clk) run_div("divu_m7_2",    0, 32'hFFFF_FFF9, 32'd2,         {32'h0000_0001, 32'h7FFF_FFFC}, 0, 1);

        // Annul at iteration 10, then a new start the very next cycle.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        check("annul_on_busy", 64'(busy_o), 64'(1));
        repeat (10) @(posedge clk);
        @(negedge clk) annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_on_busy_drop", 64'(busy_o), 64'(0));
        check("annul_on_ready", 64'(ready_o), 64'(0));
        check("annul_on_result", result_o, 64'(0));
        @(negedge clk) run_div("after_annul", 0, 32'd1000, 32'd3, {32'h0000_0001, 32'd333}, 0, 1);

        // Annul while handling a zero divisor.
        @(negedge clk);
        signed_div_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
        @(posedge clk); #1;
        check("annul_bz_busy", 64'(busy_o), 64'(1));
        @(negedge clk) annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_bz_busy_drop", 64'(busy_o), 64'(0));
        check("annul_bz_ready", 64'(ready_o), 64'(0));
        @(negedge clk) begin annul_i = 1'b0; start_i = 1'b0; end

        // annul_i in FREE blocks acceptance that cycle.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_free_busy", 64'(busy_o), 64'(0));
        @(negedge clk) begin annul_i = 1'b0; start_i = 1'b0; end

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy_o), 64'(0));
        check("rst_mid_ready", 64'(ready_o), 64'(0));
        check("rst_mid_result", result_o, 64'(0));
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div("after_reset", 0, 32'd81, 32'd9, {32'h0000_0000, 32'h0000_0009}, 0, 1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
